// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding and default width.
package timer_pkg;

  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by PRESCALE: emits a one-cycle tick every PRESCALE enabled cycles.
// The phase freezes while enable is low; clear restarts the phase at 0.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/down_timer.sv
// Loadable countdown timer with prescaled ticks and a one-cycle done pulse.
// Define DOWN_TIMER_AUTO_RELOAD_EN to reload from the reload register at zero.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             zero_q, zero_d;
  logic             psc_enable, psc_clear, tick;

  // A HOLD cycle with pause released already counts, so a pause costs exactly
  // as many cycles as pause was high.
  assign psc_enable = (state_q != ST_IDLE) && !pause && !stop;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (psc_enable),
    .clear  (psc_clear),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    psc_clear = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            count_d  = load_val;
            reload_d = load_val;
          end else if (start) begin
            if (count_q != '0) begin
              state_d   = ST_RUN;
              psc_clear = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_RUN:  if (pause)  state_d = ST_HOLD;
        ST_HOLD: if (!pause) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase

      // tick is only ever raised while running and not paused or stopped
      if (tick && count_q != '0) begin
        count_d = count_q - WIDTH'(1);
        if (count_q == WIDTH'(1)) begin
          done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      zero_q   <= zero_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = zero_q;

endmodule
